indirect_prefetcher: RTL and testbench
======================================

INDIRECT_PREFETCHER -- requirements
Module: indirect_prefetcher

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the data and index width in bits.
REQ-002 SHALL have parameter AW, default 32, meaning the byte-address width.
REQ-003 SHALL have parameter NPORT, default 2, meaning the number of parallel cache/store-buffer lanes (1..4).
REQ-004 Ports: clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Ports: reset  in  1  asynchronous, active-high reset.
REQ-006 Ports: trigger  in  1  one-cycle start pulse.
REQ-007 Ports: cfg_idx_base, cfg_val_base, cfg_out_base  in  AW each  index-array, value-array and output-array base addresses.
REQ-008 Ports: cfg_count  in  AW  number of elements; cfg_shift  in  3  value element size = 1<<cfg_shift bytes; cfg_limit  in  DW  index upper bound.
REQ-009 Ports: cache_data_req  out  1; cache_r_addr  out  NPORT*AW; cache_lane_en  out  NPORT; wait_cache  in  1; cache_data_ready  in  1; cache_data_i  in  NPORT*DW.
REQ-010 Ports: strBufWren  out  NPORT; w_addr_o  out  NPORT*AW; w_data_o  out  NPORT*DW; wait_strBuf  in  1.
REQ-011 Ports: busy  out  1; done  out  1 (one-cycle pulse); err_cnt  out  16; outState  out  4 (current state encoding).

Function
REQ-012 SHALL sample all cfg_* inputs only in the cycle trigger is accepted; trigger is accepted only in IDLE and ignored otherwise.
REQ-013 States: IDLE=0, IDX_REQ=1, IDX_WAIT=2, VAL_REQ=3, VAL_WAIT=4, WRITE=5, DONE=6.
REQ-014 IDLE->IDX_REQ on trigger with cfg_count!=0; IDLE->DONE on trigger with cfg_count==0.
REQ-015 SHALL process elements in batches of NPORT; batch base element i starts at 0 and advances by NPORT; lane k handles element i+k, enabled only if i+k < count.
REQ-016 IDX_REQ: cache_data_req=1, lane k address = idx_base + 4*(i+k), cache_lane_en = enabled lanes; request and addresses held stable while wait_cache=1; on a cycle with wait_cache=0 the request is accepted and the state moves to IDX_WAIT.
REQ-017 IDX_WAIT: on cache_data_ready=1, latch cache_data_i per enabled lane as indices and move to VAL_REQ; data on disabled lanes is discarded.
REQ-018 VAL_REQ: same handshake as REQ-016, lane k address = val_base + (idx_k << cfg_shift), truncated modulo 2^AW; -> VAL_WAIT on acceptance.
REQ-019 VAL_WAIT: on cache_data_ready=1, latch values and move to WRITE.
REQ-020 WRITE: strBufWren = enabled lanes, w_addr_o lane k = out_base + 4*(i+k), w_data_o = value; held while wait_strBuf=1; on wait_strBuf=0 the write completes, i += NPORT, and the state moves to IDX_REQ if i < count, else DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-022 cache_data_ready in any state other than IDX_WAIT/VAL_WAIT SHALL be ignored.
REQ-023 Minimum latency per batch with no waits: IDX_REQ, IDX_WAIT, VAL_REQ, VAL_WAIT, WRITE = 5 cycles when ready arrives the cycle after acceptance.
REQ-024 All outputs SHALL be registered; cache_data_req and strBufWren are 0 outside their states.

Reset
REQ-025 On reset assertion, immediately and regardless of clk, state=IDLE and all outputs=0 (including err_cnt and outState), with any in-flight batch abandoned.
REQ-026 After reset deassertion, the first trigger SHALL start a fresh operation with no residual state.

Configuration
REQ-027 Macro PREFETCH_BOUNDS_CHECK_EN: when defined, an enabled lane whose index >= cfg_limit (unsigned) SHALL be masked from the VAL_REQ lane enables, SHALL write data 0 in WRITE, and SHALL increment err_cnt (saturating at 0xFFFF); if all lanes are masked, VAL_REQ/VAL_WAIT are skipped (IDX_WAIT->WRITE).
REQ-028 When PREFETCH_BOUNDS_CHECK_EN is undefined, cfg_limit is ignored, no check is performed, and err_cnt stays 0.

Verification
REQ-029 NPORT=2, count=4, idx=[3,0,7,1], shift=2, val_base=0x1000 -> value reads at 0x100C/0x1000, then 0x101C/0x1004; 2 writes of 2 lanes at out_base+0..12; done pulse.
REQ-030 count=3, NPORT=2 -> second batch has cache_lane_en=2'b01 and strBufWren=2'b01; 2 batches total.
REQ-031 wait_cache=1 for 5 cycles during IDX_REQ -> addresses stable for all 5 cycles; single acceptance; wait_strBuf=1 for 3 cycles -> write held 3 cycles.
REQ-032 count=0 trigger -> done one cycle later, no cache_data_req; trigger while busy -> ignored, count unchanged.
REQ-033 reset asserted in VAL_WAIT -> outputs 0 same cycle; new trigger runs full sequence correctly.
REQ-034 With PREFETCH_BOUNDS_CHECK_EN, cfg_limit=5, idx=[7,2] -> lane 0 writes 0, lane 1 writes value, err_cnt=1; without the macro, both lanes load and err_cnt=0.

Source files
------------

// File: rtl/indirect_prefetcher_if.sv
// Cache read port and store-buffer write port of the indirect prefetcher, NPORT lanes wide.
interface indirect_prefetcher_if #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NPORT = 2
);
    logic                          cache_data_req;
    logic [NPORT-1:0][AW-1:0]      cache_r_addr;
    logic [NPORT-1:0]              cache_lane_en;
    logic                          wait_cache;
    logic                          cache_data_ready;
    logic [NPORT-1:0][DW-1:0]      cache_data_i;
    logic [NPORT-1:0]              strBufWren;
    logic [NPORT-1:0][AW-1:0]      w_addr_o;
    logic [NPORT-1:0][DW-1:0]      w_data_o;
    logic                          wait_strBuf;

    modport master (
        output cache_data_req, cache_r_addr, cache_lane_en,
        input  wait_cache, cache_data_ready, cache_data_i,
        output strBufWren, w_addr_o, w_data_o,
        input  wait_strBuf
    );

    modport slave (
        input  cache_data_req, cache_r_addr, cache_lane_en,
        output wait_cache, cache_data_ready, cache_data_i,
        input  strBufWren, w_addr_o, w_data_o,
        output wait_strBuf
    );
endinterface

// File: rtl/indirect_prefetcher.sv
// Gather out[i] = val[idx[i]] in NPORT-wide batches. Optional index bounds check
// is enabled with the PREFETCH_BOUNDS_CHECK_EN macro.
module indirect_prefetcher_lane #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW:0]   elem_base,
    input  logic [AW-1:0] count,
    input  logic [AW-1:0] idx_base,
    input  logic [AW-1:0] val_base,
    input  logic [AW-1:0] out_base,
    input  logic [2:0]    shift,
    input  logic [DW-1:0] limit,
    input  logic          idx_ld,
    input  logic          val_ld,
    input  logic [DW-1:0] rd_data,
    output logic          en,
    output logic          oob,
    output logic [AW-1:0] idx_addr,
    output logic [AW-1:0] val_addr,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);
    logic [DW-1:0] idx_q, val_q, idx_nxt, val_nxt;
    logic [AW:0]   elem;

    // One extra bit on the element index so i+k never wraps against count
    assign elem     = elem_base + (AW+1)'(LANE);
    assign en       = elem < {1'b0, count};
    assign idx_nxt  = (idx_ld && en) ? rd_data : idx_q;
    assign val_nxt  = (val_ld && en) ? rd_data : val_q;

`ifdef PREFETCH_BOUNDS_CHECK_EN
    assign oob = en && (idx_nxt >= limit);
`else
    logic unused_limit;
    assign unused_limit = ^limit;
    assign oob          = 1'b0;
`endif

    assign idx_addr = idx_base + AW'(elem << 2);
    assign val_addr = val_base + AW'({{AW{1'b0}}, idx_nxt} << shift);
    assign wr_addr  = out_base + AW'(elem << 2);
    assign wr_data  = oob ? '0 : val_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            val_q <= '0;
        end else begin
            idx_q <= idx_nxt;
            val_q <= val_nxt;
        end
    end
endmodule

module indirect_prefetcher #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NPORT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trigger,
    input  logic [AW-1:0]          cfg_idx_base,
    input  logic [AW-1:0]          cfg_val_base,
    input  logic [AW-1:0]          cfg_out_base,
    input  logic [AW-1:0]          cfg_count,
    input  logic [2:0]             cfg_shift,
    input  logic [DW-1:0]          cfg_limit,
    indirect_prefetcher_if.master  bus,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            err_cnt,
    output logic [3:0]             outState
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_IDX_REQ  = 3'd1;
    localparam logic [2:0] S_IDX_WAIT = 3'd2;
    localparam logic [2:0] S_VAL_REQ  = 3'd3;
    localparam logic [2:0] S_VAL_WAIT = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]    state, state_nxt;
    logic [AW:0]   elem_i, elem_i_nxt;
    logic [AW-1:0] cnt, ibase, vbase, obase;
    logic [AW-1:0] cnt_nxt, ibase_nxt, vbase_nxt, obase_nxt;
    logic [2:0]    shf, shf_nxt;
    logic [DW-1:0] lim, lim_nxt;
    logic          start, idx_ld, val_ld, wr_go, all_masked;
    logic [16:0]   bad, err_sum;
    logic [15:0]   err_nxt;

    logic [NPORT-1:0]         en, oob, val_en;
    logic [NPORT-1:0][AW-1:0] idx_addr, val_addr, wr_addr;
    logic [NPORT-1:0][DW-1:0] wr_data;

    assign start  = (state == S_IDLE) && trigger;
    assign idx_ld = (state == S_IDX_WAIT) && bus.cache_data_ready;
    assign val_ld = (state == S_VAL_WAIT) && bus.cache_data_ready;
    assign wr_go  = (state == S_WRITE) && !bus.wait_strBuf;

    // Config is captured only on an accepted trigger; lanes see the next-cycle view
    assign cnt_nxt    = start ? cfg_count    : cnt;
    assign ibase_nxt  = start ? cfg_idx_base : ibase;
    assign vbase_nxt  = start ? cfg_val_base : vbase;
    assign obase_nxt  = start ? cfg_out_base : obase;
    assign shf_nxt    = start ? cfg_shift    : shf;
    assign elem_i_nxt = start ? '0 : wr_go ? elem_i + (AW+1)'(NPORT) : elem_i;
`ifdef PREFETCH_BOUNDS_CHECK_EN
    assign lim_nxt    = start ? cfg_limit : lim;
`else
    logic unused_cfg_limit;
    assign unused_cfg_limit = ^cfg_limit;
    assign lim_nxt          = '0;
`endif

    for (genvar k = 0; k < NPORT; k++) begin : g_lane
        indirect_prefetcher_lane #(.DW(DW), .AW(AW), .LANE(k)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .elem_base(elem_i_nxt),
            .count    (cnt_nxt),
            .idx_base (ibase_nxt),
            .val_base (vbase_nxt),
            .out_base (obase_nxt),
            .shift    (shf_nxt),
            .limit    (lim_nxt),
            .idx_ld   (idx_ld),
            .val_ld   (val_ld),
            .rd_data  (bus.cache_data_i[k]),
            .en       (en[k]),
            .oob      (oob[k]),
            .idx_addr (idx_addr[k]),
            .val_addr (val_addr[k]),
            .wr_addr  (wr_addr[k]),
            .wr_data  (wr_data[k])
        );
    end

    assign val_en     = en & ~oob;
    assign all_masked = ~|val_en;

    always_comb begin
        bad = '0;
        for (int k = 0; k < NPORT; k++) bad = bad + 17'(oob[k]);
    end
    assign err_sum = {1'b0, err_cnt} + (idx_ld ? bad : 17'd0);
    assign err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (trigger) state_nxt = (cfg_count != '0) ? S_IDX_REQ : S_DONE;
            S_IDX_REQ:  if (!bus.wait_cache) state_nxt = S_IDX_WAIT;
            S_IDX_WAIT: if (bus.cache_data_ready) state_nxt = all_masked ? S_WRITE : S_VAL_REQ;
            S_VAL_REQ:  if (!bus.wait_cache) state_nxt = S_VAL_WAIT;
            S_VAL_WAIT: if (bus.cache_data_ready) state_nxt = S_WRITE;
            S_WRITE:    if (wr_go) state_nxt = (elem_i_nxt < {1'b0, cnt}) ? S_IDX_REQ : S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    assign outState = {1'b0, state};

    // Outputs are registered off the next-state view so they line up with state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            elem_i             <= '0;
            cnt                <= '0;
            ibase              <= '0;
            vbase              <= '0;
            obase              <= '0;
            shf                <= '0;
            lim                <= '0;
            err_cnt            <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            bus.cache_data_req <= 1'b0;
            bus.cache_lane_en  <= '0;
            bus.cache_r_addr   <= '0;
            bus.strBufWren     <= '0;
            bus.w_addr_o       <= '0;
            bus.w_data_o       <= '0;
        end else begin
            state              <= state_nxt;
            elem_i             <= elem_i_nxt;
            cnt                <= cnt_nxt;
            ibase              <= ibase_nxt;
            vbase              <= vbase_nxt;
            obase              <= obase_nxt;
            shf                <= shf_nxt;
            lim                <= lim_nxt;
            err_cnt            <= err_nxt;
            busy               <= state_nxt != S_IDLE;
            done               <= state_nxt == S_DONE;
            bus.cache_data_req <= (state_nxt == S_IDX_REQ) || (state_nxt == S_VAL_REQ);
            bus.cache_lane_en  <= (state_nxt == S_IDX_REQ) ? en :
                                  (state_nxt == S_VAL_REQ) ? val_en : '0;
            bus.strBufWren     <= (state_nxt == S_WRITE) ? en : '0;
            for (int k = 0; k < NPORT; k++) begin
                bus.cache_r_addr[k] <= (state_nxt == S_IDX_REQ && en[k])     ? idx_addr[k] :
                                       (state_nxt == S_VAL_REQ && val_en[k]) ? val_addr[k] : '0;
                bus.w_addr_o[k]     <= (state_nxt == S_WRITE && en[k]) ? wr_addr[k] : '0;
                bus.w_data_o[k]     <= (state_nxt == S_WRITE && en[k]) ? wr_data[k] : '0;
            end
        end
    end
endmodule

// File: tb/tb_indirect_prefetcher.sv
// Directed + randomized bench for indirect_prefetcher; the bench acts as cache and store buffer.
module tb_indirect_prefetcher;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 2;
`ifdef PREFETCH_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef logic [NP-1:0]         mask_v;
    typedef logic [NP-1:0][AW-1:0] addr_v;
    typedef logic [NP-1:0][DW-1:0] data_v;

    logic          clk = 1'b0;
    logic          reset, trigger;
    logic [AW-1:0] cfg_idx_base, cfg_val_base, cfg_out_base, cfg_count;
    logic [2:0]    cfg_shift;
    logic [DW-1:0] cfg_limit;
    logic          busy, done;
    logic [15:0]   err_cnt;
    logic [3:0]    outState;

    indirect_prefetcher_if #(.DW(DW), .AW(AW), .NPORT(NP)) bus ();

    indirect_prefetcher #(.DW(DW), .AW(AW), .NPORT(NP)) dut (
        .clk(clk), .reset(reset), .trigger(trigger),
        .cfg_idx_base(cfg_idx_base), .cfg_val_base(cfg_val_base), .cfg_out_base(cfg_out_base),
        .cfg_count(cfg_count), .cfg_shift(cfg_shift), .cfg_limit(cfg_limit),
        .bus(bus), .busy(busy), .done(done), .err_cnt(err_cnt), .outState(outState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;

    // current operation
    logic [AW-1:0] c_idx_base, c_val_base, c_out_base;
    int            c_count;
    logic [2:0]    c_shift;
    logic [DW-1:0] c_limit;
    logic [DW-1:0] idxs [16];

    mask_v q_rm[$]; addr_v q_ra[$]; bit q_rv[$];
    mask_v q_wm[$]; addr_v q_wa[$]; data_v q_wd[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] val_of(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - c_idx_base;
        if (a >= c_idx_base && off < AW'(4 * c_count) && off[1:0] == 2'b00) return idxs[off >> 2];
        return val_of(a);
    endfunction

    // Reference: per batch an index read, a value read (if any lane survives), one write
    task automatic build_model();
        for (int b = 0; b < c_count; b += NP) begin
            mask_v m, vm; addr_v ia, va, wa; data_v wd;
            m = '0; vm = '0; ia = '0; va = '0; wa = '0; wd = '0;
            for (int k = 0; k < NP; k++) begin
                int e; logic [DW-1:0] ix;
                e = b + k;
                if (e < c_count) begin
                    ix = idxs[e];
                    m[k] = 1'b1;
                    ia[k] = c_idx_base + AW'(4 * e);
                    wa[k] = c_out_base + AW'(4 * e);
                    if (BC && ix >= c_limit) begin
                        if (exp_err < 65535) exp_err++;
                    end else begin
                        vm[k] = 1'b1;
                        va[k] = c_val_base + (ix << c_shift);
                        wd[k] = val_of(va[k]);
                    end
                end
            end
            q_rm.push_back(m); q_ra.push_back(ia); q_rv.push_back(1'b0);
            if (vm != '0) begin
                q_rm.push_back(vm); q_ra.push_back(va); q_rv.push_back(1'b1);
            end
            q_wm.push_back(m); q_wa.push_back(wa); q_wd.push_back(wd);
        end
    endtask

    task automatic set_cfg(input logic [AW-1:0] ib, vb, ob, input int cnt,
                           input logic [2:0] sh, input logic [DW-1:0] lim);
        c_idx_base = ib; c_val_base = vb; c_out_base = ob;
        c_count = cnt; c_shift = sh; c_limit = lim;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   bus.cache_data_req, 0);
        check({tag, "_len"},   bus.cache_lane_en, 0);
        check({tag, "_raddr"}, bus.cache_r_addr, 0);
        check({tag, "_wren"},  bus.strBufWren, 0);
        check({tag, "_waddr"}, bus.w_addr_o, 0);
        check({tag, "_wdata"}, bus.w_data_o, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_state"}, outState, 0);
    endtask

    task automatic run_op(input bit rnd_wait, input bit forced, input bit retrig,
                          input bit abort, input bit chk_lat);
        int cyc, dly, nb, hold_n, wrh_n, n_rd, n_wr, wl, wwl;
        bit pend, fin, abort_now, w;
        data_v pdata;
        build_model();
        nb = (c_count + NP - 1) / NP;
        cyc = 0; dly = 0; hold_n = 0; wrh_n = 0; n_rd = 0; n_wr = 0;
        pend = 0; fin = 0; abort_now = 0; pdata = '0;
        wl = forced ? 5 : 0; wwl = forced ? 3 : 0;

        @(negedge clk);
        cfg_idx_base = c_idx_base; cfg_val_base = c_val_base; cfg_out_base = c_out_base;
        cfg_count = AW'(c_count); cfg_shift = c_shift; cfg_limit = c_limit;
        trigger = 1'b1;
        @(negedge clk);
        while (!fin && cyc < 2000) begin
            if (abort_now) begin
                check("abort_state", outState, 4);
                reset = 1'b1;
                #1;
                check_quiet("abort");
                check("abort_err", err_cnt, 0);
                @(negedge clk);
                reset = 1'b0; trigger = 1'b0;
                bus.cache_data_ready = 1'b0; bus.wait_cache = 1'b0; bus.wait_strBuf = 1'b0;
                q_rm.delete(); q_ra.delete(); q_rv.delete();
                q_wm.delete(); q_wa.delete(); q_wd.delete();
                exp_err = 0;
                return;
            end
            if (cyc == 0) check("first_state", outState, (c_count == 0) ? 6 : 1);
            check("busy", busy, 1);
            // config and trigger activity while busy must be ignored
            trigger = retrig && (cyc == 2);
            cfg_count = AW'($urandom_range(0, 9)); cfg_idx_base = $urandom;
            cfg_val_base = $urandom; cfg_out_base = $urandom;
            cfg_shift = 3'($urandom); cfg_limit = $urandom_range(0, 15);

            bus.cache_data_ready = 1'b0;
            for (int k = 0; k < NP; k++) bus.cache_data_i[k] = $urandom;
            if (pend) begin
                if (dly == 0) begin
                    bus.cache_data_ready = 1'b1; bus.cache_data_i = pdata; pend = 0;
                end else dly--;
            end else if ($urandom_range(0, 3) == 0) bus.cache_data_ready = 1'b1;

            if (bus.cache_data_req) begin
                if (n_rd == 0) hold_n++;
                if (q_rm.size() == 0) check("rd_extra", bus.cache_data_req, 0);
                else begin
                    check("rd_mask", bus.cache_lane_en, q_rm[0]);
                    for (int k = 0; k < NP; k++)
                        if (q_rm[0][k]) check($sformatf("rd_addr%0d", k), bus.cache_r_addr[k], q_ra[0][k]);
                end
                if (wl > 0) begin w = 1; wl--; end
                else w = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
                bus.wait_cache = w;
                if (!w && q_rm.size() != 0) begin
                    for (int k = 0; k < NP; k++)
                        pdata[k] = q_rm[0][k] ? mem_rd(q_ra[0][k]) : $urandom;
                    if (abort && q_rv[0]) abort_now = 1;
                    q_rm.pop_front(); q_ra.pop_front(); q_rv.pop_front();
                    pend = 1; n_rd++;
                    dly = rnd_wait ? $urandom_range(0, 2) : 0;
                end
            end else bus.wait_cache = 1'($urandom);

            if (bus.strBufWren != '0) begin
                if (n_wr == 0) wrh_n++;
                if (q_wm.size() == 0) check("wr_extra", bus.strBufWren, 0);
                else begin
                    check("wr_mask", bus.strBufWren, q_wm[0]);
                    for (int k = 0; k < NP; k++)
                        if (q_wm[0][k]) begin
                            check($sformatf("wr_addr%0d", k), bus.w_addr_o[k], q_wa[0][k]);
                            check($sformatf("wr_data%0d", k), bus.w_data_o[k], q_wd[0][k]);
                        end
                end
                if (wwl > 0) begin w = 1; wwl--; end
                else w = rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
                bus.wait_strBuf = w;
                if (!w && q_wm.size() != 0) begin
                    q_wm.pop_front(); q_wa.pop_front(); q_wd.pop_front(); n_wr++;
                end
            end else bus.wait_strBuf = 1'($urandom);

            if (done) begin
                fin = 1;
                check("rd_left", q_rm.size(), 0);
                check("wr_left", q_wm.size(), 0);
                check("err_cnt", err_cnt, exp_err);
                if (chk_lat) check("latency", cyc, 5 * nb);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("timeout", fin, 1);
        if (forced) begin
            check("idx_hold_cycles", hold_n, 6);
            check("wr_hold_cycles", wrh_n, 4);
        end
        trigger = 1'b0;
        @(negedge clk);
        check_quiet("post_done");
    endtask

    initial begin
        reset = 1'b0; trigger = 1'b0;
        cfg_idx_base = '0; cfg_val_base = '0; cfg_out_base = '0;
        cfg_count = '0; cfg_shift = '0; cfg_limit = '0;
        bus.wait_cache = 1'b0; bus.cache_data_ready = 1'b0;
        bus.cache_data_i = '0; bus.wait_strBuf = 1'b0;

        // reset must clear outputs before any clock edge
        #2 reset = 1'b1;
        #1;
        check_quiet("reset");
        check("reset_err", err_cnt, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // idx=[3,0,7,1], shift 2, val_base 0x1000
        idxs[0] = 3; idxs[1] = 0; idxs[2] = 7; idxs[3] = 1;
        set_cfg(32'h100, 32'h1000, 32'h8000, 4, 3'd2, 32'd100);
        run_op(0, 0, 0, 0, 1);

        // odd count: partial second batch
        set_cfg(32'h200, 32'h3000, 32'h9000, 3, 3'd1, 32'd100);
        run_op(0, 0, 0, 0, 1);

        // forced stalls: 5 cycles on first index request, 3 on first write
        set_cfg(32'h300, 32'h4000, 32'hA000, 2, 3'd3, 32'd100);
        run_op(0, 1, 0, 0, 0);

        // empty operation
        set_cfg(32'h400, 32'h5000, 32'hB000, 0, 3'd0, 32'd0);
        run_op(0, 0, 0, 0, 1);

        // retrigger while busy, random stalls
        idxs[0] = 5; idxs[1] = 2; idxs[2] = 9; idxs[3] = 4;
        set_cfg(32'h500, 32'h6000, 32'hC000, 4, 3'd2, 32'd100);
        run_op(1, 0, 1, 0, 0);

        // reset during value wait, then a clean rerun
        run_op(0, 0, 0, 1, 0);
        run_op(0, 0, 0, 0, 1);

        // bounds case: idx=[7,2], limit 5
        idxs[0] = 7; idxs[1] = 2;
        set_cfg(32'h600, 32'h7000, 32'hD000, 2, 3'd2, 32'd5);
        run_op(0, 0, 0, 0, 1);

        // fully out-of-range first batch
        idxs[0] = 9; idxs[1] = 8; idxs[2] = 1;
        set_cfg(32'h700, 32'h7800, 32'hE000, 3, 3'd0, 32'd5);
        run_op(1, 0, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 16; k++) idxs[k] = $urandom_range(0, 15);
            set_cfg(32'h0010_0000 + ($urandom_range(0, 255) << 4),
                    32'h2000_0000 + ($urandom_range(0, 255) << 8),
                    32'h4000_0000 + ($urandom_range(0, 255) << 8),
                    $urandom_range(1, 7), 3'($urandom_range(0, 3)),
                    $urandom_range(0, 15));
            run_op(1, 0, ($urandom_range(0, 3) == 0), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
